// File: rtl/func2_pkg.sv
// Shared types and constants for the functionality-2 execution controller:
// FSM state enum, request codes from the upstream verifier, and the width
// of the remaining-cycles counter.
package func2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_HOLD = 3'd4
    } state_e;

    localparam logic [1:0] REQ_NONE    = 2'b00;
    localparam logic [1:0] REQ_A       = 2'b01;
    localparam logic [1:0] REQ_B       = 2'b10;
    localparam logic [1:0] REQ_ILLEGAL = 2'b11;

    localparam int REM_W = 8;

endpackage

// File: rtl/func2_timer.sv
// Loadable down-counter used as the RUN-length timer.
// Priority: clear over load over enable; the count saturates at zero.
module func2_timer
    import func2_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [REM_W-1:0] load_val,
    input  logic             en,
    input  logic             clr,
    output logic [REM_W-1:0] count,
    output logic             zero
);

    logic [REM_W-1:0] count_q;
    logic [REM_W-1:0] count_d;

    // next count: clear, load, or decrement without wrapping
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/exec_funcionality2.sv
// Execution controller for functionality-2 requests.
// A request must be stable for STABLE_CYCLES samples before a RUN of
// DURATION cycles is granted to its owner; HOLD waits for the request to
// clear so one press yields one operation.
// Optional macro FUNC2_ABORT_EN: a request change during RUN aborts it
// straight to HOLD without a done pulse.
//
// state | meaning
// IDLE  | waiting for a request code
// ARM   | request seen, counting stable samples
// RUN   | operation granted, timer counting down
// DONE  | one-cycle completion pulse
// HOLD  | waiting for the request to return to none
module exec_funcionality2
    import func2_pkg::*;
#(
    parameter int DURATION      = 10,
    parameter int STABLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] S,
    output logic [1:0] grant,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] remaining
);

    localparam logic [REM_W-1:0] DUR_V    = REM_W'(DURATION);
    localparam logic [3:0]       STAB_LIM = 4'(STABLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [3:0]       stable_q, stable_d;
    logic [1:0]       grant_q, grant_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             tmr_load, tmr_en, tmr_clr, tmr_zero;
    logic [REM_W-1:0] tmr_count;

    func2_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (DUR_V),
        .en       (tmr_en),
        .clr      (tmr_clr),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    // state, request bookkeeping and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= REQ_NONE;
            stable_q <= '0;
            grant_q  <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            stable_q <= stable_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // next-state, owner capture and timer control
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        stable_d = stable_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_clr  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if ((S == REQ_A) || (S == REQ_B)) begin
                    owner_d  = S;
                    stable_d = 4'd1;
                    state_d  = ST_ARM;
                end
            end
            ST_ARM: begin
                if (S == owner_q) begin
                    if (stable_q >= STAB_LIM) begin
                        stable_d = '0;
                        tmr_load = 1'b1;
                        state_d  = ST_RUN;
                    end else begin
                        stable_d = stable_q + 4'd1;
                    end
                end else begin
                    owner_d  = REQ_NONE;
                    stable_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
`ifdef FUNC2_ABORT_EN
                if (S != owner_q) begin
                    tmr_clr = 1'b1;
                    state_d = ST_HOLD;
                end else
`endif
                // zero only reachable if DURATION were 0; finish rather than stall
                if (tmr_zero || (tmr_count == REM_W'(1))) begin
                    tmr_clr = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (S == REQ_NONE) begin
                    owner_d = REQ_NONE;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                owner_d  = REQ_NONE;
                stable_d = '0;
                tmr_clr  = 1'b1;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // output values registered alongside the state they describe
    always_comb begin
        grant_d = (state_d == ST_RUN) ? owner_d : 2'b00;
        busy_d  = (state_d == ST_ARM) || (state_d == ST_RUN) || (state_d == ST_DONE);
        done_d  = (state_d == ST_DONE);
        err_d   = (state_q == ST_IDLE) && (S == REQ_ILLEGAL);
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign remaining = tmr_count;

endmodule

// File: tb/tb_exec_funcionality2.sv
// Scoreboard bench for exec_funcionality2 with DURATION=4, STABLE_CYCLES=2.
// A reference model steps on every rising edge and queues the expected
// outputs; a monitor pops and compares on every falling edge.
module tb_exec_funcionality2;

    localparam int DUR  = 4;
    localparam int STAB = 2;
`ifdef FUNC2_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_DONE = 3, M_HOLD = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] S     = 2'b00;
    logic [1:0] grant;
    logic       busy, done, err;
    logic [7:0] remaining;

    int checks = 0;
    int errors = 0;

    logic [12:0] exp_q[$];
    logic [12:0] mon_exp, mon_act;
    bit          reset_seen = 1'b0;

    int m_mode = M_IDLE;
    int m_owner = 0;
    int m_streak = 0;
    int m_left = 0;
    bit m_err = 1'b0;

    always #5 clk = ~clk;

    exec_funcionality2 #(
        .DURATION      (DUR),
        .STABLE_CYCLES (STAB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .S         (S),
        .grant     (grant),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .remaining (remaining)
    );

    function void model_reset();
        m_mode   = M_IDLE;
        m_owner  = 0;
        m_streak = 0;
        m_left   = 0;
        m_err    = 1'b0;
    endfunction

    // one sampled request applied to the behavioural rules
    function void model_step(input int s);
        m_err = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (s == 1 || s == 2) begin
                    m_owner  = s;
                    m_streak = 1;
                    m_mode   = M_ARM;
                end else if (s == 3) begin
                    m_err = 1'b1;
                end
            end
            M_ARM: begin
                if (s == m_owner) begin
                    m_streak = m_streak + 1;
                    if (m_streak >= STAB) begin
                        m_mode = M_RUN;
                        m_left = DUR;
                    end
                end else begin
                    m_mode = M_IDLE;
                end
            end
            M_RUN: begin
                if (ABORT && s != m_owner) begin
                    m_mode = M_HOLD;
                    m_left = 0;
                end else if (m_left == 1) begin
                    m_mode = M_DONE;
                    m_left = 0;
                end else begin
                    m_left = m_left - 1;
                end
            end
            M_DONE: m_mode = M_HOLD;
            default: if (s == 0) m_mode = M_IDLE;
        endcase
    endfunction

    function logic [12:0] model_out();
        logic [1:0] g;
        logic       b, d;
        logic [7:0] r;
        g = (m_mode == M_RUN) ? 2'(m_owner) : 2'b00;
        b = (m_mode == M_ARM) || (m_mode == M_RUN) || (m_mode == M_DONE);
        d = (m_mode == M_DONE);
        r = (m_mode == M_RUN) ? 8'(m_left) : 8'd0;
        return {g, b, d, m_err, r};
    endfunction

    // reference model: expected outputs after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
            end else begin
                if (reset_seen) begin
                    model_reset();
                    reset_seen = 1'b0;
                end
                model_step(int'(S));
            end
            exp_q.push_back(model_out());
        end
    end

    // monitor: compare DUT outputs against the queued expectation
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_act = {grant, busy, done, err, remaining};
                checks++;
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL outputs t=%0t actual grant=%b busy=%b done=%b err=%b rem=%0d required grant=%b busy=%b done=%b err=%b rem=%0d",
                             $time, mon_act[12:11], mon_act[10], mon_act[9], mon_act[8], mon_act[7:0],
                             mon_exp[12:11], mon_exp[10], mon_exp[9], mon_exp[8], mon_exp[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            S = s;
            @(posedge clk);
            #1;
        end
    endtask

    // reset pulse entirely between a falling and the next rising edge
    task automatic async_pulse();
        @(negedge clk);
        #1;
        rst_n      = 1'b0;
        reset_seen = 1'b1;
        #1;
        chk("async_grant", 32'(grant), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        chk("async_remaining", 32'(remaining), 32'd0);
        S = 2'b00;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        int len;
        logic [1:0] s;

        // held in reset with a request present
        rst_n = 1'b0;
        S     = 2'b01;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("reset_outputs", 32'({grant, busy, done, err, remaining}), 32'd0);
        S     = 2'b00;
        rst_n = 1'b1;
        drive(2'b00, 2);

        drive(2'b01, 8);   // normal A request through HOLD
        drive(2'b00, 3);
        drive(2'b10, 1);   // glitch on B
        drive(2'b00, 3);
        drive(2'b11, 1);   // illegal code
        drive(2'b00, 2);
        drive(2'b01, 3);   // drop during the second RUN cycle
        drive(2'b00, 8);
        drive(2'b10, 3);   // async reset during RUN
        async_pulse();
        drive(2'b00, 8);

        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)      s = 2'b00;
            else if (r < 7) s = 2'b01;
            else if (r < 9) s = 2'b10;
            else            s = 2'b11;
            len = int'($urandom_range(1, 8));
            drive(s, len);
            if ($urandom_range(0, 39) == 0) async_pulse();
        end
        drive(2'b00, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_funcionality2.md
EXEC_FUNCIONALITY2 -- requirements
Module: exec_funcionality2

Interface
REQ-001 SHALL have parameter DURATION, default 10, meaning RUN length in clock cycles (legal range 1..255).
REQ-002 SHALL have parameter STABLE_CYCLES, default 2, meaning consecutive identical request samples needed before RUN (legal range 1..15).
REQ-003 SHALL have port clk, input, 1, the single system clock, with all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port S, input, 2, request code from the upstream functionality-2 verifier: 01 = side A, 10 = side B, 00 = none, 11 = illegal.
REQ-006 SHALL have port grant, output, 2, one-hot owner of the running operation, 00 when none.
REQ-007 SHALL have port busy, output, 1, high in ARM, RUN and DONE.
REQ-008 SHALL have port done, output, 1, one-cycle pulse at normal completion.
REQ-009 SHALL have port err, output, 1, one-cycle pulse when S==11 is sampled in IDLE.
REQ-010 SHALL have port remaining, output, 8, cycles left in RUN, 0 outside RUN.

Function
REQ-011 SHALL implement FSM states IDLE, ARM, RUN, DONE and HOLD, and no others.
REQ-012 In IDLE, S in {01,10} SHALL capture owner=S, set stable count=1 and go to ARM; S==00 SHALL stay in IDLE; S==11 SHALL pulse err and stay in IDLE.
REQ-013 In ARM, S equal to owner SHALL increment stable count, and reaching STABLE_CYCLES SHALL enter RUN with remaining=DURATION.
REQ-014 In ARM, S differing from owner SHALL return to IDLE with no grant, no err and no done.
REQ-015 In RUN, grant SHALL equal owner for exactly DURATION cycles, with remaining decrementing by 1 per cycle and reaching 1 on the final RUN cycle.
REQ-016 Leaving RUN SHALL go to DONE for exactly one cycle, with done=1 and grant=00.
REQ-017 DONE SHALL go to HOLD.
REQ-018 HOLD SHALL stay until S==00, then go to IDLE, so one request press yields one operation.
REQ-019 All outputs SHALL be registered, with no combinational path from S to any output.
REQ-020 done and err SHALL never be high in the same cycle.
REQ-021 grant SHALL never be 11.
REQ-022 The remaining counter SHALL never wrap below 0.

Reset
REQ-023 rst_n low SHALL immediately, without waiting for clk, force state=IDLE, grant=00, busy=0, done=0, err=0, remaining=0 and clear owner and stable count.
REQ-024 Reset asserted mid-RUN SHALL abandon the operation with no done pulse after release.
REQ-025 After rst_n rises, the first rising edge SHALL evaluate IDLE rules.

Configuration
REQ-026 Macro FUNC2_ABORT_EN defined: S!=owner sampled in RUN SHALL end RUN next cycle, setting grant=00 and remaining=0, skipping DONE (no done pulse), and going to HOLD.
REQ-027 Macro FUNC2_ABORT_EN undefined: RUN SHALL ignore S and always complete DURATION cycles followed by DONE.

Structure
REQ-028 Package func2_pkg SHALL hold the FSM state enum, the request code constants (REQ_NONE, REQ_A, REQ_B, REQ_ILLEGAL) and the remaining-counter width constant.
REQ-029 Sub-module func2_timer SHALL provide a loadable 8-bit down-counter with load, enable, clear and zero flag; the FSM and output registers remain in exec_funcionality2.

Verification (DURATION=4, STABLE_CYCLES=2)
REQ-030 Bench SHALL check reset: hold rst_n=0 -> all outputs 0; drive S=01 while in reset -> outputs remain 0.
REQ-031 Bench SHALL check a normal A request: hold S=01 from edge 0 -> ARM at edge 0, RUN at edge 1, grant=01 for 4 cycles with remaining 4,3,2,1, done=1 for 1 cycle, then HOLD until S=00.
REQ-032 Bench SHALL check a glitch: S=10 for 1 cycle then 00 -> ARM then IDLE, grant stays 00, done stays 0.
REQ-033 Bench SHALL check an illegal code: S=11 in IDLE -> err=1 for one cycle, busy=0, state stays IDLE.
REQ-034 Bench SHALL check a request drop mid-RUN: S=01, drop to 00 on the 2nd RUN cycle -> with FUNC2_ABORT_EN grant=00 next cycle and no done; without it grant lasts 4 cycles and then done=1.
REQ-035 Bench SHALL check asynchronous reset: pulse rst_n low between clock edges during RUN -> grant and busy fall before the next edge, and no done follows.
